// File: rtl/ast_dma_cmd_queue.sv
// Descriptor queue between the GPP DMA register-write port and the DMA engine.
// Stages field writes, queues committed descriptors, replays them as DMA writes and tracks completion.
module ast_dma_cmd_queue #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NFIELD    = 6,
  parameter int unsigned START_SEL = 7,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         wr_in,
  input  logic [2:0]                   select_in,
  input  logic [DATAWIDTH-1:0]         data_in,
  input  logic                         dma_busy_in,
  output logic                         dma_write_out,
  output logic [2:0]                   dma_select_out,
  output logic [DATAWIDTH-1:0]         dma_data_out,
  output logic                         pause_out,
  output logic [$clog2(DEPTH):0]       count_out,
  output logic                         done_out,
  output logic                         overflow_out,
  output logic                         timeout_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = $clog2(NFIELD + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  localparam logic [2:0] SEL_CTRL   = 3'd6;
  localparam logic [2:0] SEL_COMMIT = 3'd7;

  typedef logic [NFIELD-1:0][DATAWIDTH-1:0] desc_t;

  desc_t            stage_q;
  desc_t            issue_q;
  desc_t            mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             wait_mode_q;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             write_d, done_d, timeout_set;
  logic [2:0]       sel_d;
  logic [DATAWIDTH-1:0] data_d;

  logic ctrl_wr, commit, flush, err_clr, fifo_full, pop, push, drop;

  // Register-port decode and FIFO push/pop qualification
  assign ctrl_wr   = wr_in && (select_in == SEL_CTRL);
  assign commit    = wr_in && (select_in == SEL_COMMIT);
  assign flush     = ctrl_wr && data_in[0];
  assign err_clr   = ctrl_wr && data_in[1];
  assign fifo_full = (count_q == CNT_W'(DEPTH));
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  // A flush empties the FIFO before the push, so the push always fits
  assign push      = commit && (flush || !fifo_full || pop);
  assign drop      = commit && !push;

  assign count_out = count_q;
  assign pause_out = fifo_full || (wait_mode_q && ((count_q != '0) || (state_q != S_IDLE)));

  // Shadow descriptor staging
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stage_q <= '0;
    end else if (wr_in && (select_in < 3'(NFIELD))) begin
      stage_q[select_in] <= data_in;
    end
  end

  // FIFO storage, no reset needed: validity is tracked by count_q
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= stage_q;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
        count_q  <= push ? CNT_W'(1) : '0;
      end else begin
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Sticky status and wait-mode
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      overflow_out <= 1'b0;
      timeout_out  <= 1'b0;
      wait_mode_q  <= 1'b0;
    end else begin
      overflow_out <= drop || (overflow_out && !err_clr);
      timeout_out  <= timeout_set || (timeout_out && !err_clr);
      if (ctrl_wr) wait_mode_q <= data_in[2];
    end
  end

  // Replay FSM next-state and DMA output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    write_d     = 1'b0;
    sel_d       = dma_select_out;
    data_d      = dma_data_out;
    done_d      = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        write_d = 1'b1;
        if (idx_q == IDX_W'(NFIELD)) begin
          sel_d   = 3'(START_SEL);
          data_d  = '0;
          state_d = S_WAIT_START;
          tmr_d   = '0;
        end else begin
          sel_d  = 3'(idx_q);
          data_d = issue_q[idx_q];
          idx_d  = idx_q + IDX_W'(1);
        end
      end
      S_WAIT_START: begin
        if (dma_busy_in) begin
          state_d = S_WAIT_DONE;
        end else if (tmr_q == TMR_W'(TIMEOUT)) begin
          timeout_set = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!dma_busy_in) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Replay FSM state, issue register and registered DMA outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tmr_q          <= '0;
      issue_q        <= '0;
      dma_write_out  <= 1'b0;
      dma_select_out <= '0;
      dma_data_out   <= '0;
      done_out       <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tmr_q          <= tmr_d;
      dma_write_out  <= write_d;
      dma_select_out <= sel_d;
      dma_data_out   <= data_d;
      done_out       <= done_d;
      if (pop) issue_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_ast_dma_cmd_queue.sv
// Directed self-checking bench for ast_dma_cmd_queue with a small DMA busy model.
module tb_ast_dma_cmd_queue;

  localparam int M_RESP = 0;
  localparam int M_HOLD = 1;
  localparam int M_NONE = 2;

  logic        Clock;
  logic        Resetn;
  logic        wr_in;
  logic [2:0]  select_in;
  logic [15:0] data_in;
  logic        dma_busy_in;
  logic        dma_write_out;
  logic [2:0]  dma_select_out;
  logic [15:0] dma_data_out;
  logic        pause_out;
  logic [2:0]  count_out;
  logic        done_out;
  logic        overflow_out;
  logic        timeout_out;

  int errors = 0;
  int checks = 0;
  int dma_mode = M_RESP;
  int busy_left = 0;

  ast_dma_cmd_queue dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .wr_in          (wr_in),
    .select_in      (select_in),
    .data_in        (data_in),
    .dma_busy_in    (dma_busy_in),
    .dma_write_out  (dma_write_out),
    .dma_select_out (dma_select_out),
    .dma_data_out   (dma_data_out),
    .pause_out      (pause_out),
    .count_out      (count_out),
    .done_out       (done_out),
    .overflow_out   (overflow_out),
    .timeout_out    (timeout_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // DMA model: responsive (busy 3 cycles after START), held busy, or never busy
  initial begin
    dma_busy_in = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (dma_mode == M_HOLD) begin
        dma_busy_in = 1'b1;
        busy_left = 0;
      end else if (dma_mode == M_NONE) begin
        dma_busy_in = 1'b0;
        busy_left = 0;
      end else begin
        if (busy_left != 0) begin
          busy_left--;
          if (busy_left == 0) dma_busy_in = 1'b0;
        end
        if (dma_write_out && dma_select_out == 3'd7) begin
          dma_busy_in = 1'b1;
          busy_left = 3;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [15:0] d);
    wr_in = 1'b1;
    select_in = s;
    data_in = d;
    tick();
    wr_in = 1'b0;
  endtask

  task automatic test_reset();
    wr_in = 1'b0; select_in = 3'd0; data_in = 16'h0;
    Resetn = 1'b1;
    #2 Resetn = 1'b0;
    #1;
    checks++;
    if ({dma_write_out, dma_select_out, dma_data_out} !== 20'h0) begin
      errors++; $display("FAIL reset_dma: got %0h expected 0", {dma_write_out, dma_select_out, dma_data_out});
    end
    checks++;
    if ({pause_out, count_out, done_out, overflow_out, timeout_out} !== 7'h0) begin
      errors++; $display("FAIL reset_status: got %0h expected 0", {pause_out, count_out, done_out, overflow_out, timeout_out});
    end
    tick(); tick();
    Resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [2:0]  got_sel [16];
    logic [15:0] got_data [16];
    int          got_t [16];
    int n_wr = 0;
    int n_done = 0;
    logic [2:0] exp_sel;
    logic [15:0] exp_data;
    dma_mode = M_RESP;
    for (int i = 0; i < 6; i++) wr(3'(i), 16'h10 + 16'(i));
    wr(3'd7, 16'h0);
    checks++;
    if (count_out !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", count_out); end
    tick();
    checks++;
    if ({count_out, dma_write_out} !== 4'b0000) begin
      errors++; $display("FAIL basic_pop: got count=%0d write=%0b expected 0/0", count_out, dma_write_out);
    end
    tick();
    checks++;
    if ({dma_write_out, dma_select_out, dma_data_out} !== {1'b1, 3'd0, 16'h10}) begin
      errors++; $display("FAIL basic_first_write: got w=%0b s=%0d d=%0h expected 1/0/10", dma_write_out, dma_select_out, dma_data_out);
    end
    got_sel[0] = dma_select_out; got_data[0] = dma_data_out; got_t[0] = 0; n_wr = 1;
    for (int t = 1; t < 40; t++) begin
      tick();
      if (dma_write_out && n_wr < 16) begin
        got_sel[n_wr] = dma_select_out; got_data[n_wr] = dma_data_out; got_t[n_wr] = t; n_wr++;
      end
      if (done_out) n_done++;
    end
    checks++;
    if (n_wr !== 7) begin errors++; $display("FAIL basic_nwrites: got %0d expected 7", n_wr); end
    for (int i = 0; i < 7 && i < n_wr; i++) begin
      exp_sel  = (i == 6) ? 3'd7 : 3'(i);
      exp_data = (i == 6) ? 16'h0 : 16'h10 + 16'(i);
      checks++;
      if (got_sel[i] !== exp_sel || got_data[i] !== exp_data || got_t[i] !== i) begin
        errors++;
        $display("FAIL basic_write%0d: got s=%0d d=%0h t=%0d expected s=%0d d=%0h t=%0d",
                 i, got_sel[i], got_data[i], got_t[i], exp_sel, exp_data, i);
      end
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", n_done); end
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL basic_count_end: got %0d expected 0", count_out); end
  endtask

  task automatic test_overflow();
    bit found = 0;
    dma_mode = M_HOLD;
    wr(3'd7, 16'h0);
    tick();
    wr(3'd7, 16'h0); wr(3'd7, 16'h0); wr(3'd7, 16'h0);
    checks++;
    if ({count_out, pause_out} !== {3'd3, 1'b0}) begin
      errors++; $display("FAIL ovf_count3: got count=%0d pause=%0b expected 3/0", count_out, pause_out);
    end
    wr(3'd7, 16'h0);
    checks++;
    if ({count_out, pause_out, overflow_out} !== {3'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ovf_full: got count=%0d pause=%0b ovf=%0b expected 4/1/0", count_out, pause_out, overflow_out);
    end
    wr(3'd7, 16'h0);
    checks++;
    if ({count_out, overflow_out} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL ovf_drop: got count=%0d ovf=%0b expected 4/1", count_out, overflow_out);
    end
    wr(3'd6, 16'h2);
    checks++;
    if ({count_out, overflow_out} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL ovf_clear: got count=%0d ovf=%0b expected 4/0", count_out, overflow_out);
    end
    wr(3'd6, 16'h1);
    checks++;
    if ({count_out, pause_out} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL ovf_flush: got count=%0d pause=%0b expected 0/0", count_out, pause_out);
    end
    dma_mode = M_NONE;
    for (int t = 0; t < 30 && !found; t++) begin
      tick();
      if (done_out) found = 1;
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL ovf_release_done: got %0b expected 1", found); end
  endtask

  task automatic test_full_pop_commit();
    bit found = 0;
    dma_mode = M_HOLD;
    wr(3'd7, 16'h0);
    tick();
    for (int i = 0; i < 4; i++) wr(3'd7, 16'h0);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (count_out !== 3'd4) begin errors++; $display("FAIL fpc_setup: got %0d expected 4", count_out); end
    dma_mode = M_NONE;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (done_out) found = 1;
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL fpc_done: got %0b expected 1", found); end
    wr(3'd7, 16'h0);
    checks++;
    if ({count_out, overflow_out, timeout_out} !== {3'd4, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fpc_accept: got count=%0d ovf=%0b to=%0b expected 4/0/0", count_out, overflow_out, timeout_out);
    end
  endtask

  task automatic test_timeout();
    int start_t = -1;
    int done_t = -1;
    logic to_at_done = 1'b0;
    bit found = 0;
    for (int t = 0; t < 60 && done_t < 0; t++) begin
      tick();
      if (dma_write_out && dma_select_out == 3'd7) start_t = t;
      if (done_out) begin done_t = t; to_at_done = timeout_out; end
    end
    checks++;
    if (done_t - start_t !== 16 || start_t < 0) begin
      errors++; $display("FAIL to_latency: got start=%0d done=%0d expected gap 16", start_t, done_t);
    end
    checks++;
    if (to_at_done !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b expected 1", to_at_done); end
    tick(); tick();
    checks++;
    if ({dma_write_out, dma_select_out} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL to_next_issue: got w=%0b s=%0d expected 1/0", dma_write_out, dma_select_out);
    end
    wr(3'd6, 16'h1);
    checks++;
    if (count_out !== 3'd0) begin errors++; $display("FAIL to_flush: got %0d expected 0", count_out); end
    for (int t = 0; t < 60 && !found; t++) begin
      tick();
      if (done_out) found = 1;
    end
    wr(3'd6, 16'h2);
    checks++;
    if ({found, timeout_out} !== 2'b10) begin
      errors++; $display("FAIL to_clear: got done=%0b to=%0b expected 1/0", found, timeout_out);
    end
  endtask

  task automatic test_flush_inflight();
    bit seen = 0;
    int n_done = 0;
    int n_wr = 0;
    dma_mode = M_RESP;
    wr(3'd7, 16'h0); wr(3'd7, 16'h0); wr(3'd7, 16'h0);
    checks++;
    if (count_out !== 3'd2) begin errors++; $display("FAIL fl_queued: got %0d expected 2", count_out); end
    for (int t = 0; t < 40 && !seen; t++) begin
      tick();
      if (dma_write_out && dma_select_out == 3'd7) seen = 1;
    end
    tick();
    wr(3'd6, 16'h1);
    checks++;
    if ({seen, count_out} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL fl_flush: got seen=%0b count=%0d expected 1/0", seen, count_out);
    end
    for (int t = 0; t < 40; t++) begin
      tick();
      if (done_out) n_done++;
      if (dma_write_out) n_wr++;
    end
    checks++;
    if ({n_done, n_wr} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL fl_after: got done=%0d writes=%0d expected 1/0", n_done, n_wr);
    end
  endtask

  task automatic test_wait_mode();
    bit found = 0;
    dma_mode = M_RESP;
    wr(3'd6, 16'h4);
    checks++;
    if (pause_out !== 1'b0) begin errors++; $display("FAIL wm_idle: got %0b expected 0", pause_out); end
    wr(3'd7, 16'h0);
    tick();
    checks++;
    if ({count_out, pause_out} !== {3'd0, 1'b1}) begin
      errors++; $display("FAIL wm_inflight: got count=%0d pause=%0b expected 0/1", count_out, pause_out);
    end
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (done_out) found = 1;
    end
    checks++;
    if ({found, pause_out} !== 2'b10) begin
      errors++; $display("FAIL wm_done: got done=%0b pause=%0b expected 1/0", found, pause_out);
    end
    wr(3'd6, 16'h0);
  endtask

  task automatic test_reset_midissue();
    int n_wr = 0;
    dma_mode = M_RESP;
    wr(3'd7, 16'h0);
    wr(3'd7, 16'h0);
    tick();
    tick();
    checks++;
    if ({dma_write_out, dma_select_out, dma_data_out} !== {1'b1, 3'd1, 16'h11}) begin
      errors++; $display("FAIL rst_pre: got w=%0b s=%0d d=%0h expected 1/1/11", dma_write_out, dma_select_out, dma_data_out);
    end
    Resetn = 1'b0;
    #1;
    checks++;
    if ({dma_write_out, dma_select_out, dma_data_out, count_out, done_out} !== 24'h0) begin
      errors++; $display("FAIL rst_async: got w=%0b s=%0d d=%0h c=%0d done=%0b expected all 0",
                         dma_write_out, dma_select_out, dma_data_out, count_out, done_out);
    end
    tick();
    Resetn = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (dma_write_out) n_wr++;
    end
    checks++;
    if ({n_wr, count_out} !== {32'd0, 3'd0}) begin
      errors++; $display("FAIL rst_after: got writes=%0d count=%0d expected 0/0", n_wr, count_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop_commit();
    test_timeout();
    test_flush_inflight();
    test_wait_mode();
    test_reset_midissue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
